ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline, directly downstream of the ID/EX pipeline register. It consumes that register's control and data outputs.
- Performs single-cycle ALU operations (add/sub/and/or/slt/sll/srl).
- Performs a 32-iteration shift-add unsigned multiply. The multiply stalls upstream via stall_out.
- Drives the EX/MEM register contents, which are held internally.

---
 rtl/ex_pkg.sv | 33 +++
 rtl/ex_seq_multiplier.sv | 95 +++++++++
 rtl/ex_stage.sv | 152 +++++++++++++++
 tb/tb_ex_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ----------------------------------------------------------------------------
// ex_pkg
// Shared definitions for the MIPS execute stage:
//   - ALU_OP encodings driven by the decode stage
//   - R-type funct codes understood by the ALU (plus the multiply funct)
//   - state encoding of the iterative multiplier FSM
// ----------------------------------------------------------------------------
package ex_pkg;

    // ALU_OP field coming from the ID/EX register
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_SLT   = 2'b11;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_MUL = 6'h18;

    // Iterative multiplier FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/ex_seq_multiplier.sv
// ----------------------------------------------------------------------------
// ex_seq_multiplier
// 32-iteration shift-add unsigned multiplier with start/busy/done handshake.
// All state updates on the falling clock edge, matching the pipeline.
//
// Ports:
//   clk          in   pipeline clock (negedge active)
//   rst          in   synchronous active-high reset
//   start        in   multiply requested; only accepted in IDLE
//   multiplicand in   DATA_W  first operand, latched on acceptance
//   multiplier   in   DATA_W  second operand, latched on acceptance
//   busy         out  registered, high while the 32 steps are running
//   done         out  registered, high for the one cycle the product is ready
//   product      out  DATA_W  low word of the 64-bit accumulator
//
// Timing: accept edge -> 32 step edges -> MUL_DONE for one edge -> IDLE.
// The MUL_DONE edge never re-accepts start, so an instruction still held at
// the inputs while its result is collected is not launched a second time.
// ----------------------------------------------------------------------------
module ex_seq_multiplier
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [DATA_W-1:0] multiplier,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    mul_state_e          state_q;
    logic [4:0]          count_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [2*DATA_W-1:0] acc_q;

    // One FSM block: the multiplicand is shifted left and the multiplier
    // shifted right each step, so bit 0 of mplier_q always selects whether
    // the current weighted multiplicand is added into the accumulator.
    // busy/done are registered alongside the state so they are glitch-free.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= {{DATA_W{1'b0}}, multiplicand};
                        mplier_q <= multiplier;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy     <= 1'b1;
                        state_q  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The high word is intentionally dropped: mult keeps only the low 32 bits
    assign product = acc_q[DATA_W-1:0];

endmodule

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
// Execute stage of the 5-stage MIPS pipeline. Sits behind the ID/EX register,
// computes the ALU result and holds the EX/MEM register contents internally.
// All state updates on the falling clock edge; rst is synchronous.
//
// Build option: define MULT_EN to include the iterative multiplier
// (ex_seq_multiplier). Without it stall_out is tied low and the multiply
// funct decodes like any undefined funct (result 0, one-edge latency).
//
// Ports:
//   clk, rst                          clock (negedge) / sync active-high reset
//   wb_in, mem_read_in, mem_write_in,
//   mem2reg_in                        control bits from ID/EX
//   ALU_src_in                        1 = operand B is I_tar_data_in
//   reg_dst_in                        1 = destination is R_dst_addr_in
//   ALU_OP_in [1:0]                   00 add, 01 sub, 10 R-type, 11 slt
//   src_data_in, R_tar_data_in,
//   I_tar_data_in [DATA_W-1:0]        rs, rt, sign-extended immediate
//   shamt_in [4:0], funct_ctrl_in [5:0]
//   R_dst_addr_in, I_dst_addr_in [4:0] rd / rt addresses
//   wb_out, mem_read_out, mem_write_out, mem2reg_out  EX/MEM control
//   alu_result_out, store_data_out [DATA_W-1:0]       EX/MEM data
//   dst_addr_out [4:0]                EX/MEM destination
//   stall_out                         combinational hold request upstream
// Only DATA_W = 32 is supported.
// ----------------------------------------------------------------------------
module ex_stage
    import ex_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter logic [5:0] MUL_FUNCT = FN_MUL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              mem2reg_in,
    input  logic              ALU_src_in,
    input  logic              reg_dst_in,
    input  logic [1:0]        ALU_OP_in,
    input  logic [DATA_W-1:0] src_data_in,
    input  logic [DATA_W-1:0] R_tar_data_in,
    input  logic [DATA_W-1:0] I_tar_data_in,
    input  logic [4:0]        shamt_in,
    input  logic [4:0]        R_dst_addr_in,
    input  logic [4:0]        I_dst_addr_in,
    input  logic [5:0]        funct_ctrl_in,
    output logic              wb_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              mem2reg_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [4:0]        dst_addr_out,
    output logic              stall_out
);

    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] ex_result;
    logic [4:0]        dst_sel;
    logic              is_mul;
    logic              insert_bubble;

    assign op_b    = ALU_src_in ? I_tar_data_in : R_tar_data_in;
    assign dst_sel = reg_dst_in ? R_dst_addr_in : I_dst_addr_in;
    assign is_mul  = (ALU_OP_in == ALU_OP_RTYPE) && (funct_ctrl_in == MUL_FUNCT);

    // Single-cycle ALU. Arithmetic wraps modulo 2^32, slt is signed.
    // A multiply funct never yields an ALU value: with the multiplier built
    // in, the product replaces it; without it, it acts as an undefined funct.
    always_comb begin
        alu_result = '0;
        case (ALU_OP_in)
            ALU_OP_ADD: alu_result = src_data_in + op_b;
            ALU_OP_SUB: alu_result = src_data_in - op_b;
            ALU_OP_SLT: alu_result = {{(DATA_W-1){1'b0}},
                                      ($signed(src_data_in) < $signed(op_b))};
            default: begin
                case (funct_ctrl_in)
                    FN_ADD:  alu_result = src_data_in + op_b;
                    FN_SUB:  alu_result = src_data_in - op_b;
                    FN_AND:  alu_result = src_data_in & op_b;
                    FN_OR:   alu_result = src_data_in | op_b;
                    FN_SLT:  alu_result = {{(DATA_W-1){1'b0}},
                                           ($signed(src_data_in) < $signed(op_b))};
                    FN_SLL:  alu_result = op_b << shamt_in;
                    FN_SRL:  alu_result = op_b >> shamt_in;
                    default: alu_result = '0;
                endcase
            end
        endcase
        if (is_mul) begin
            alu_result = '0;
        end
    end

`ifdef MULT_EN
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    ex_seq_multiplier #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk          (clk),
        .rst          (rst),
        .start        (is_mul),
        .multiplicand (src_data_in),
        .multiplier   (op_b),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (mul_product)
    );

    // Hold upstream while a multiply is being accepted (IDLE with a multiply
    // at the inputs) or running. In MUL_DONE the held instruction is retired,
    // so the pipeline is released on that edge.
    assign insert_bubble = mul_busy || (is_mul && !mul_done);
    assign stall_out     = !rst && insert_bubble;
    assign ex_result     = mul_done ? mul_product : alu_result;
`else
    assign insert_bubble = 1'b0;
    assign stall_out     = 1'b0;
    assign ex_result     = alu_result;
`endif

    // EX/MEM register. A bubble is the same all-zero value as reset, so
    // both share one branch.
    always_ff @(negedge clk) begin
        if (rst || insert_bubble) begin
            wb_out         <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            mem2reg_out    <= 1'b0;
            alu_result_out <= '0;
            store_data_out <= '0;
            dst_addr_out   <= '0;
        end else begin
            wb_out         <= wb_in;
            mem_read_out   <= mem_read_in;
            mem_write_out  <= mem_write_in;
            mem2reg_out    <= mem2reg_in;
            alu_result_out <= ex_result;
            store_data_out <= R_tar_data_in;
            dst_addr_out   <= dst_sel;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage
// Self-checking bench for ex_stage. A transaction-level reference model
// predicts the EX/MEM contents after every falling edge and the stall request
// between edges; a compare process checks every cycle. Directed scenarios
// with literal expectations run first, then randomized traffic.
// Works with or without MULT_EN defined.
// ----------------------------------------------------------------------------
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_in, mem_read_in, mem_write_in, mem2reg_in;
    logic        ALU_src_in, reg_dst_in;
    logic [1:0]  ALU_OP_in;
    logic [31:0] src_data_in, R_tar_data_in, I_tar_data_in;
    logic [4:0]  shamt_in, R_dst_addr_in, I_dst_addr_in;
    logic [5:0]  funct_ctrl_in;
    logic        wb_out, mem_read_out, mem_write_out, mem2reg_out;
    logic [31:0] alu_result_out, store_data_out;
    logic [4:0]  dst_addr_out;
    logic        stall_out;

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .wb_in          (wb_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .mem2reg_in     (mem2reg_in),
        .ALU_src_in     (ALU_src_in),
        .reg_dst_in     (reg_dst_in),
        .ALU_OP_in      (ALU_OP_in),
        .src_data_in    (src_data_in),
        .R_tar_data_in  (R_tar_data_in),
        .I_tar_data_in  (I_tar_data_in),
        .shamt_in       (shamt_in),
        .R_dst_addr_in  (R_dst_addr_in),
        .I_dst_addr_in  (I_dst_addr_in),
        .funct_ctrl_in  (funct_ctrl_in),
        .wb_out         (wb_out),
        .mem_read_out   (mem_read_out),
        .mem_write_out  (mem_write_out),
        .mem2reg_out    (mem2reg_out),
        .alu_result_out (alu_result_out),
        .store_data_out (store_data_out),
        .dst_addr_out   (dst_addr_out),
        .stall_out      (stall_out)
    );

    // Free-running clock; the design is active on the falling edge
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model state
    //   m_phase: 0 = no multiply in flight, 1..32 = edges since acceptance
    //   while the product is being formed, 33 = product ready to retire
    // ------------------------------------------------------------------
    int          m_phase = 0;
    logic [63:0] m_prod = '0;
    logic        m_valid = 1'b0;
    logic        m_stalled_last = 1'b0;
    logic        exp_wb, exp_mr, exp_mw, exp_m2r;
    logic [31:0] exp_res, exp_store;
    logic [4:0]  exp_dst;

    function automatic logic mul_present();
`ifdef MULT_EN
        return (ALU_OP_in == 2'b10) && (funct_ctrl_in == 6'h18);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] operand_b();
        return ALU_src_in ? I_tar_data_in : R_tar_data_in;
    endfunction

    function automatic logic [31:0] alu_ref();
        logic [31:0] a;
        logic [31:0] b;
        a = src_data_in;
        b = operand_b();
        case (ALU_OP_in)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin
                case (funct_ctrl_in)
                    6'h20:   return a + b;
                    6'h22:   return a - b;
                    6'h24:   return a & b;
                    6'h25:   return a | b;
                    6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00:   return b << shamt_in;
                    6'h02:   return b >> shamt_in;
                    default: return 32'd0;
                endcase
            end
        endcase
    endfunction

    function automatic logic stall_ref();
        return !rst && ((m_phase == 0 && mul_present()) ||
                        (m_phase >= 1 && m_phase <= 32));
    endfunction

    task automatic set_bubble();
        exp_wb    = 1'b0;
        exp_mr    = 1'b0;
        exp_mw    = 1'b0;
        exp_m2r   = 1'b0;
        exp_res   = 32'd0;
        exp_store = 32'd0;
        exp_dst   = 5'd0;
    endtask

    // Model advances on every falling edge from the inputs alone
    always @(negedge clk) begin
        logic [63:0] ma;
        logic [63:0] mb;
        m_stalled_last = stall_ref();
        if (rst) begin
            set_bubble();
            m_phase = 0;
        end else if (m_phase == 0 && mul_present()) begin
            set_bubble();
            ma      = {32'd0, src_data_in};
            mb      = {32'd0, operand_b()};
            m_prod  = ma * mb;
            m_phase = 1;
        end else if (m_phase >= 1 && m_phase <= 32) begin
            set_bubble();
            m_phase = m_phase + 1;
        end else begin
            exp_wb    = wb_in;
            exp_mr    = mem_read_in;
            exp_mw    = mem_write_in;
            exp_m2r   = mem2reg_in;
            exp_res   = (m_phase == 33) ? m_prod[31:0] : alu_ref();
            exp_store = R_tar_data_in;
            exp_dst   = reg_dst_in ? R_dst_addr_in : I_dst_addr_in;
            m_phase   = 0;
        end
        m_valid = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual,
                     expected, $time);
        end
    endtask

    // Compare process: outputs are stable mid-cycle at the rising edge
    always @(posedge clk) begin
        if (m_valid) begin
            checkOutput("wb_out",         {31'd0, wb_out},        {31'd0, exp_wb});
            checkOutput("mem_read_out",   {31'd0, mem_read_out},  {31'd0, exp_mr});
            checkOutput("mem_write_out",  {31'd0, mem_write_out}, {31'd0, exp_mw});
            checkOutput("mem2reg_out",    {31'd0, mem2reg_out},   {31'd0, exp_m2r});
            checkOutput("alu_result_out", alu_result_out,         exp_res);
            checkOutput("store_data_out", store_data_out,         exp_store);
            checkOutput("dst_addr_out",   {27'd0, dst_addr_out},  {27'd0, exp_dst});
            checkOutput("stall_out",      {31'd0, stall_out},     {31'd0, stall_ref()});
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                                 input logic [31:0] src, input logic [31:0] rtar,
                                 input logic [31:0] imm, input logic alusrc,
                                 input logic regdst, input logic [4:0] rd,
                                 input logic [4:0] rt, input logic [4:0] shamt,
                                 input logic wb, input logic mr, input logic mw,
                                 input logic m2r);
        ALU_OP_in     = op;
        funct_ctrl_in = funct;
        src_data_in   = src;
        R_tar_data_in = rtar;
        I_tar_data_in = imm;
        ALU_src_in    = alusrc;
        reg_dst_in    = regdst;
        R_dst_addr_in = rd;
        I_dst_addr_in = rt;
        shamt_in      = shamt;
        wb_in         = wb;
        mem_read_in   = mr;
        mem_write_in  = mw;
        mem2reg_in    = m2r;
        #1;
    endtask

    // Counts falling edges that occur while stall_out is high; bounded
    task automatic runMultiply(output int stall_edges);
        stall_edges = 0;
        for (int i = 0; i < 40 && stall_out; i++) begin
            stall_edges++;
            nextCycle();
        end
    endtask

    function automatic logic [31:0] randData();
        logic [31:0] corners [4];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'h7FFF_FFFF;
        case ($urandom_range(0, 3))
            0:       return corners[$urandom_range(0, 3)];
            1:       return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    task automatic randomInputs();
        logic [5:0] functs [8];
        functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24; functs[3] = 6'h25;
        functs[4] = 6'h2A; functs[5] = 6'h00; functs[6] = 6'h02; functs[7] = 6'h18;
        ALU_OP_in     = 2'($urandom_range(0, 3));
        funct_ctrl_in = ($urandom_range(0, 9) < 8) ? functs[$urandom_range(0, 7)]
                                                   : 6'($urandom);
        src_data_in   = randData();
        R_tar_data_in = randData();
        I_tar_data_in = randData();
        ALU_src_in    = 1'($urandom);
        reg_dst_in    = 1'($urandom);
        R_dst_addr_in = 5'($urandom);
        I_dst_addr_in = 5'($urandom);
        shamt_in      = 5'($urandom);
        wb_in         = 1'($urandom);
        mem_read_in   = 1'($urandom);
        mem_write_in  = 1'($urandom);
        mem2reg_in    = 1'($urandom);
    endtask

    // Directed scenarios with literal expectations, then random traffic
    initial begin
        int edges;
        logic mult_built;
`ifdef MULT_EN
        mult_built = 1'b1;
`else
        mult_built = 1'b0;
`endif
        rst = 1'b1;
        applyStimulus(2'b00, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) nextCycle();
        checkOutput("reset alu_result", alu_result_out, 32'd0);
        checkOutput("reset wb_out", {31'd0, wb_out}, 32'd0);
        checkOutput("reset dst_addr", {27'd0, dst_addr_out}, 32'd0);
        checkOutput("reset stall_out", {31'd0, stall_out}, 32'd0);
        rst = 1'b0;

        // add wraps into the sign bit, rd selected
        applyStimulus(2'b10, 6'h20, 32'h7FFF_FFFF, 32'h1, 32'h0, 0, 1, 5'd5, 5'd3, 0, 1, 0, 0, 0);
        nextCycle();
        checkOutput("add overflow result", alu_result_out, 32'h8000_0000);
        checkOutput("add dst", {27'd0, dst_addr_out}, 32'd5);

        // signed slt: -1 < 1
        applyStimulus(2'b11, 6'h00, 32'hFFFF_FFFF, 32'h0, 32'h1, 1, 0, 5'd0, 5'd4, 0, 1, 0, 0, 0);
        nextCycle();
        checkOutput("slt signed", alu_result_out, 32'd1);

        // logical right shift of operand B
        applyStimulus(2'b10, 6'h02, 32'h0, 32'hF000_0000, 32'h0, 0, 1, 5'd6, 5'd0, 5'd4, 1, 0, 0, 0);
        nextCycle();
        checkOutput("srl result", alu_result_out, 32'h0F00_0000);

        // sw address generation
        applyStimulus(2'b00, 6'h00, 32'h100, 32'hDEAD_BEEF, 32'h8, 1, 0, 5'd0, 5'd2, 0, 0, 0, 1, 0);
        nextCycle();
        checkOutput("sw address", alu_result_out, 32'h108);
        checkOutput("sw store data", store_data_out, 32'hDEAD_BEEF);
        checkOutput("sw mem_write", {31'd0, mem_write_out}, 32'd1);

        // single multiply: 0000FFFF * 00010001 = 00000000_FFFFFFFF
        applyStimulus(2'b10, 6'h18, 32'h0000_FFFF, 32'h0001_0001, 32'h0, 0, 1, 5'd9, 5'd1, 0, 1, 0, 0, 0);
        runMultiply(edges);
        checkOutput("mul stall edges", edges, mult_built ? 32'd33 : 32'd0);
        nextCycle();
        checkOutput("mul result", alu_result_out, mult_built ? 32'hFFFF_FFFF : 32'd0);
        checkOutput("mul dst", {27'd0, dst_addr_out}, 32'd9);
        checkOutput("mul wb", {31'd0, wb_out}, 32'd1);

        // back-to-back multiplies
        applyStimulus(2'b10, 6'h18, 32'd3, 32'd5, 32'h0, 0, 1, 5'd10, 5'd1, 0, 1, 0, 0, 0);
        runMultiply(edges);
        nextCycle();
        checkOutput("b2b first result", alu_result_out, mult_built ? 32'h0000_000F : 32'd0);
        applyStimulus(2'b10, 6'h18, 32'hFFFF_FFFF, 32'd2, 32'h0, 0, 1, 5'd11, 5'd1, 0, 1, 0, 0, 0);
        runMultiply(edges);
        checkOutput("b2b second stall edges", edges, mult_built ? 32'd33 : 32'd0);
        nextCycle();
        checkOutput("b2b second result", alu_result_out, mult_built ? 32'hFFFF_FFFE : 32'd0);
        checkOutput("b2b second dst", {27'd0, dst_addr_out}, 32'd11);

        // reset mid-multiply, after acceptance plus ten steps
        applyStimulus(2'b10, 6'h18, 32'd7, 32'd9, 32'h0, 0, 1, 5'd12, 5'd1, 0, 1, 0, 0, 0);
        repeat (11) nextCycle();
        rst = 1'b1;
        repeat (2) nextCycle();
        rst = 1'b0;
        applyStimulus(2'b00, 6'h00, 32'd2, 32'd3, 32'h0, 0, 0, 5'd0, 5'd7, 0, 1, 0, 0, 0);
        checkOutput("post-reset stall", {31'd0, stall_out}, 32'd0);
        checkOutput("post-reset result", alu_result_out, 32'd0);
        checkOutput("post-reset wb", {31'd0, wb_out}, 32'd0);
        nextCycle();
        checkOutput("alu after reset", alu_result_out, 32'd5);
        checkOutput("alu after reset dst", {27'd0, dst_addr_out}, 32'd7);

        // Randomized traffic; ID/EX only advances when the last edge did
        // not stall, as the upstream pipeline would behave
        for (int n = 0; n < 3000; n++) begin
            logic hold;
            hold = m_stalled_last;
            rst  = ($urandom_range(0, 79) == 0);
            if (!hold) begin
                randomInputs();
            end
            nextCycle();
        end

        rst = 1'b0;
        applyStimulus(2'b00, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (40) nextCycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #400000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
